// File: rtl/mod_down_pkg.sv
// Shared types for the modulo down-counter: FSM encoding and default width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mod_down_pkg;

  // Default counter width when the instantiating block does not override it.
  localparam int DEF_WIDTH = 3;

  // Run/idle/done controller states. The encoding is fixed so that the
  // state register reads the same in waveforms across related counters.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mod_down_pkg

// File: rtl/mod_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles.
// Latency: tick is combinational from the internal phase counter and en.
// Backpressure: en low freezes the phase; clr restarts the phase at zero.
module mod_prescaler
  import mod_down_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // PRESCALE=1 still needs a one-bit phase register to stay a legal width.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] phase;

  // Tick on the last phase of each period, only while counting is enabled.
  assign tick = en && (phase == PS_LAST);

  // Phase counter: cleared by reset or clr, advances only while enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      if (phase == PS_LAST) begin
        phase <= '0;
      end else begin
        phase <= phase + PS_W'(1);
      end
    end
  end

endmodule : mod_prescaler

// File: rtl/mod_down_counter.sv
// Loadable modulo down-counter/timer with periodic or one-shot mode and a
// registered terminal-count pulse. Optional tick prescaler: MOD_DOWN_PRESCALE_EN.
// Latency: start loads on its edge, first decrement one edge later; tc is
// registered, high in the cycle after the terminal edge.
// Backpressure: none; en low stalls the count, stop aborts to IDLE.
module mod_down_counter
  import mod_down_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  // A prescale below one has no meaningful rate; the counter then never
  // ticks rather than silently running at an unintended speed.
  localparam logic PS_OK = (PRESCALE >= 1);

  state_t state;
  logic   tick;

`ifdef MOD_DOWN_PRESCALE_EN
  logic ps_tick;

  // The divider only advances while actually counting, and restarts its
  // phase on any start or stop so every run sees a full first period.
  mod_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (start || stop),
    .en   (en && (state == ST_RUN)),
    .tick (ps_tick)
  );

  assign tick = PS_OK && ps_tick;
`else
  assign tick = PS_OK && en;
`endif

  // Status flags are a pure decode of the state register.
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Controller and datapath: rst > stop > start > tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      tc    <= 1'b0;
    end else if (stop) begin
      // Abort keeps the count visible for inspection.
      state <= ST_IDLE;
      tc    <= 1'b0;
    end else if (start) begin
      // Restart wins over a coincident terminal tick, so no tc here.
      state <= ST_RUN;
      count <= mod_val;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        ST_RUN: begin
          if (tick) begin
            if (count != '0) begin
              count <= count - WIDTH'(1);
            end else begin
              tc <= 1'b1;
              if (oneshot) begin
                state <= ST_DONE;
              end else begin
                // mod_val is sampled here, so mid-run edits apply now.
                count <= mod_val;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mod_down_counter
